// File: rtl/ctrl_pkg.sv
// Purpose : shared types and constants for the control sequencer: state enum,
//           opcode values, Ctl strobe bit positions and AluOp codes.
// Latency : n/a (declarations only). Backpressure: n/a.
package ctrl_pkg;

  // Ctl strobe bit positions (bit 0 is the LSB of Ctl).
  localparam int CTL_W       = 20;
  localparam int CTL_PCOUT   = 0;
  localparam int CTL_ZHIOUT  = 1;
  localparam int CTL_ZLOWOUT = 2;
  localparam int CTL_MDROUT  = 3;
  localparam int CTL_MARIN   = 4;
  localparam int CTL_ZIN     = 5;
  localparam int CTL_PCIN    = 6;
  localparam int CTL_MDRIN   = 7;
  localparam int CTL_IRIN    = 8;
  localparam int CTL_YIN     = 9;
  localparam int CTL_INCPC   = 10;
  localparam int CTL_READ    = 11;
  localparam int CTL_WRITE   = 12;
  localparam int CTL_GRA     = 13;
  localparam int CTL_GRB     = 14;
  localparam int CTL_GRC     = 15;
  localparam int CTL_RIN     = 16;
  localparam int CTL_ROUT    = 17;
  localparam int CTL_BAOUT   = 18;
  localparam int CTL_COUT    = 19;

  // ALU operation codes; everything else is reserved.
  localparam int unsigned ALU_ADD = 0;
  localparam int unsigned ALU_SUB = 1;
  localparam int unsigned ALU_AND = 2;
  localparam int unsigned ALU_OR  = 3;

  // Opcode values.
  localparam int unsigned OP_LD   = 0;
  localparam int unsigned OP_LDI  = 1;
  localparam int unsigned OP_ST   = 2;
  localparam int unsigned OP_ADD  = 3;
  localparam int unsigned OP_SUB  = 4;
  localparam int unsigned OP_AND  = 5;
  localparam int unsigned OP_OR   = 6;
  localparam int unsigned OP_ADDI = 12;
  localparam int unsigned OP_NOP  = 26;
  localparam int unsigned OP_HALT = 27;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  // Opcodes collapse onto a handful of execution shapes.
  typedef enum logic [2:0] {
    CL_LD, CL_LDI, CL_ST, CL_ALU, CL_ADDI, CL_NOP, CL_HALT, CL_ILL
  } opc_class_t;

  function automatic opc_class_t classify(input int unsigned opc);
    case (opc)
      OP_LD:                          return CL_LD;
      OP_LDI:                         return CL_LDI;
      OP_ST:                          return CL_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR:  return CL_ALU;
      OP_ADDI:                        return CL_ADDI;
      OP_NOP:                         return CL_NOP;
      OP_HALT:                        return CL_HALT;
      default:                        return CL_ILL;
    endcase
  endfunction

  // ALU select for register-register ops; ADD for anything else.
  function automatic int unsigned alu_code(input int unsigned opc);
    case (opc)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Purpose : bundle between the control sequencer (master) and the datapath
//           (slave). Ports: IR/MemReady/Stop into the sequencer; Ctl/AluOp/Run/
//           IllegalOp out of it. Latency/backpressure: wires only.
interface control_sequencer_if #(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 4
) ();

  logic [DATA_W-1:0]          IR;
  logic                       MemReady;
  logic                       Stop;
  logic [ctrl_pkg::CTL_W-1:0] Ctl;
  logic [ALUOP_W-1:0]         AluOp;
  logic                       Run;
  logic                       IllegalOp;

  modport master (
    input  IR, MemReady, Stop,
    output Ctl, AluOp, Run, IllegalOp
  );

  modport slave (
    output IR, MemReady, Stop,
    input  Ctl, AluOp, Run, IllegalOp
  );

endinterface

// File: rtl/ctrl_decode.sv
// Purpose : combinational decode of (state, opcode) into Ctl strobes, AluOp, IllegalOp.
// Latency : 0 cycles (pure combinational).
// Backpressure: MemReady only gates the PC update strobes inside the fetch wait.
// Ports   : state, opcode, mem_ready in; ctl, alu_op, illegal_op out.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPC_W   = 5,
  parameter int ALUOP_W = 4
) (
  input  state_t             state,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               mem_ready,
  output logic [CTL_W-1:0]   ctl,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal_op
);

  opc_class_t cls;

  assign cls = classify(32'(opcode));

  always_comb begin
    ctl        = '0;
    alu_op     = '0;
    illegal_op = 1'b0;
    case (state)
      S_T0: begin
        ctl[CTL_PCOUT] = 1'b1;
        ctl[CTL_MARIN] = 1'b1;
        ctl[CTL_INCPC] = 1'b1;
        ctl[CTL_ZIN]   = 1'b1;
      end
      S_T1: begin
        // Read/MDRin stay up through the wait; the incremented PC is only
        // committed in the completing cycle so a stall cannot double-load it.
        ctl[CTL_READ]    = 1'b1;
        ctl[CTL_MDRIN]   = 1'b1;
        ctl[CTL_ZLOWOUT] = mem_ready;
        ctl[CTL_PCIN]    = mem_ready;
      end
      S_T2: begin
        ctl[CTL_MDROUT] = 1'b1;
        ctl[CTL_IRIN]   = 1'b1;
      end
      S_T3: begin
        case (cls)
          CL_LD, CL_LDI, CL_ST: begin
            ctl[CTL_GRB]   = 1'b1;
            ctl[CTL_BAOUT] = 1'b1;
            ctl[CTL_YIN]   = 1'b1;
          end
          CL_ALU, CL_ADDI: begin
            ctl[CTL_GRB]  = 1'b1;
            ctl[CTL_ROUT] = 1'b1;
            ctl[CTL_YIN]  = 1'b1;
          end
          CL_ILL:  illegal_op = 1'b1;
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          CL_LD, CL_LDI, CL_ST, CL_ADDI: begin
            ctl[CTL_COUT] = 1'b1;
            ctl[CTL_ZIN]  = 1'b1;
            alu_op        = ALUOP_W'(ALU_ADD);
          end
          CL_ALU: begin
            ctl[CTL_GRC]  = 1'b1;
            ctl[CTL_ROUT] = 1'b1;
            ctl[CTL_ZIN]  = 1'b1;
            alu_op        = ALUOP_W'(alu_code(32'(opcode)));
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          CL_LD, CL_ST: begin
            ctl[CTL_ZLOWOUT] = 1'b1;
            ctl[CTL_MARIN]   = 1'b1;
          end
          CL_LDI, CL_ALU, CL_ADDI: begin
            ctl[CTL_ZLOWOUT] = 1'b1;
            ctl[CTL_GRA]     = 1'b1;
            ctl[CTL_RIN]     = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls)
          CL_LD: begin
            ctl[CTL_READ]  = 1'b1;
            ctl[CTL_MDRIN] = 1'b1;
          end
          CL_ST: begin
            ctl[CTL_GRA]   = 1'b1;
            ctl[CTL_ROUT]  = 1'b1;
            ctl[CTL_MDRIN] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (cls)
          CL_LD: begin
            ctl[CTL_MDROUT] = 1'b1;
            ctl[CTL_GRA]    = 1'b1;
            ctl[CTL_RIN]    = 1'b1;
          end
          CL_ST:   ctl[CTL_WRITE] = 1'b1;
          default: ;
        endcase
      end
      default: ;  // IDLE and HALT drive nothing
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Purpose : hardwired T-state control sequencer; owns the state register and
//           transitions, strobes come from ctrl_decode.
// Latency : 6 cycles for LDI/ALU/ADDI, 8 for LD/ST, +1 per MemReady=0 cycle.
// Backpressure: MemReady=0 holds T1/T6(LD)/T7(ST); Stop=1 parks in IDLE at instruction boundaries.
// Ports   : Clock, Clear (sync, active-low), bus (master modport of control_sequencer_if).
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int OPC_W   = 5,
  parameter int ALUOP_W = 4
) (
  input  logic                 Clock,
  input  logic                 Clear,
  control_sequencer_if.master  bus
);

  state_t           state;
  logic             run_q;
  logic [OPC_W-1:0] opcode;
  opc_class_t       cls;
  logic             unused_ir;

  // The T2 branch (NOP/HALT) relies on the datapath presenting the incoming
  // instruction on IR while IRin is asserted (write-through IR load).
  assign opcode    = bus.IR[DATA_W-1 -: OPC_W];
  assign cls       = classify(32'(opcode));
  assign unused_ir = ^bus.IR[DATA_W-OPC_W-1:0];

  // Every instruction end goes through here, so Stop is only ever honoured
  // between instructions.
  function automatic state_t boundary(input logic stop);
    return stop ? S_IDLE : S_T0;
  endfunction

  function automatic state_t next_state(input state_t s, input opc_class_t c,
                                        input logic mr, input logic stop);
    state_t n;
    n = s;
    case (s)
      S_IDLE: n = boundary(stop);
      S_T0:   n = S_T1;
      S_T1:   n = mr ? S_T2 : S_T1;
      S_T2: begin
        case (c)
          CL_NOP:  n = boundary(stop);
          CL_HALT: n = S_HALT;
          default: n = S_T3;
        endcase
      end
      S_T3:   n = (c == CL_ILL) ? boundary(stop) : S_T4;
      S_T4:   n = S_T5;
      S_T5:   n = (c == CL_LD || c == CL_ST) ? S_T6 : boundary(stop);
      S_T6: begin
        if (c == CL_LD) n = mr ? S_T7 : S_T6;
        else            n = S_T7;
      end
      S_T7: begin
        if (c == CL_ST) n = mr ? boundary(stop) : S_T7;
        else            n = boundary(stop);
      end
      S_HALT: n = S_HALT;  // only Clear leaves HALT
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

  function automatic logic running(input state_t s);
    return (s != S_IDLE) && (s != S_HALT);
  endfunction

  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state <= S_IDLE;
      run_q <= 1'b0;
    end else begin
      state <= next_state(state, cls, bus.MemReady, bus.Stop);
      // Run is registered from the next state so it lines up with the state.
      run_q <= running(next_state(state, cls, bus.MemReady, bus.Stop));
    end
  end

  ctrl_decode #(
    .OPC_W   (OPC_W),
    .ALUOP_W (ALUOP_W)
  ) u_decode (
    .state      (state),
    .opcode     (opcode),
    .mem_ready  (bus.MemReady),
    .ctl        (bus.Ctl),
    .alu_op     (bus.AluOp),
    .illegal_op (bus.IllegalOp)
  );

  assign bus.Run = run_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Purpose : directed self-checking bench for control_sequencer; each task runs
//           one instruction scenario from reset and compares every cycle.
// Ports   : none (top-level bench).
module tb_control_sequencer;

  logic Clock;
  logic Clear;
  int   errors;
  int   checks;

  control_sequencer_if #(.DATA_W(32), .ALUOP_W(4)) bus ();

  control_sequencer #(.DATA_W(32), .OPC_W(5), .ALUOP_W(4)) dut (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Strobe bits in the fixed Ctl order, LSB first.
  localparam logic [19:0] PCOUT  = 20'd1 << 0;
  localparam logic [19:0] ZLOW   = 20'd1 << 2;
  localparam logic [19:0] MDROUT = 20'd1 << 3;
  localparam logic [19:0] MARIN  = 20'd1 << 4;
  localparam logic [19:0] ZIN    = 20'd1 << 5;
  localparam logic [19:0] PCIN   = 20'd1 << 6;
  localparam logic [19:0] MDRIN  = 20'd1 << 7;
  localparam logic [19:0] IRIN   = 20'd1 << 8;
  localparam logic [19:0] YIN    = 20'd1 << 9;
  localparam logic [19:0] INCPC  = 20'd1 << 10;
  localparam logic [19:0] READ   = 20'd1 << 11;
  localparam logic [19:0] WRITE  = 20'd1 << 12;
  localparam logic [19:0] GRA    = 20'd1 << 13;
  localparam logic [19:0] GRB    = 20'd1 << 14;
  localparam logic [19:0] GRC    = 20'd1 << 15;
  localparam logic [19:0] RIN    = 20'd1 << 16;
  localparam logic [19:0] ROUT   = 20'd1 << 17;
  localparam logic [19:0] BAOUT  = 20'd1 << 18;
  localparam logic [19:0] COUT   = 20'd1 << 19;

  localparam logic [19:0] C_T0  = PCOUT | MARIN | INCPC | ZIN;
  localparam logic [19:0] C_T1W = READ | MDRIN;
  localparam logic [19:0] C_T1  = READ | MDRIN | ZLOW | PCIN;
  localparam logic [19:0] C_T2  = MDROUT | IRIN;
  localparam logic [19:0] C_WB  = ZLOW | GRA | RIN;

  // One clock cycle: inputs applied during it, outputs expected in it.
  typedef struct packed {
    logic        clr;
    logic        mr;
    logic        stop;
    logic [19:0] ctl;
    logic [3:0]  alu;
    logic        run;
    logic        ill;
  } step_t;

  function automatic step_t st(logic clr, logic mr, logic stop, logic [19:0] ctl,
                               logic [3:0] alu, logic run, logic ill);
    return '{clr, mr, stop, ctl, alu, run, ill};
  endfunction

  // Common case: out of reset, memory ready, no stop, no ALU op, legal.
  function automatic step_t sn(logic [19:0] ctl, logic run);
    return st(1'b1, 1'b1, 1'b0, ctl, 4'd0, run, 1'b0);
  endfunction

  function automatic logic [31:0] instr(int op);
    return 32'(op) << 27;
  endfunction

  // Stimulus only: load IR and pull Clear for one edge; ends just after the edge.
  task automatic apply_reset(input logic [31:0] ir);
    bus.IR       = ir;
    bus.Stop     = 1'b0;
    bus.MemReady = 1'b1;
    Clear        = 1'b0;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset;
    step_t s[$];
    apply_reset(instr(1));
    checks++; if (bus.Ctl !== 20'd0) begin errors++; $display("FAIL reset Ctl got %h want %h", bus.Ctl, 20'd0); end
    checks++; if (bus.AluOp !== 4'd0) begin errors++; $display("FAIL reset AluOp got %0d want 0", bus.AluOp); end
    checks++; if (bus.Run !== 1'b0) begin errors++; $display("FAIL reset Run got %b want 0", bus.Run); end
    checks++; if (bus.IllegalOp !== 1'b0) begin errors++; $display("FAIL reset IllegalOp got %b want 0", bus.IllegalOp); end
    // First T0 one cycle after Clear returns high.
    s.push_back(sn(20'd0, 1'b0));
    s.push_back(sn(C_T0, 1'b1));
    foreach (s[i]) begin
      Clear = s[i].clr; bus.MemReady = s[i].mr; bus.Stop = s[i].stop;
      #1;
      checks++; if (bus.Ctl !== s[i].ctl) begin errors++; $display("FAIL reset_exit[%0d] Ctl got %h want %h", i, bus.Ctl, s[i].ctl); end
      checks++; if (bus.Run !== s[i].run) begin errors++; $display("FAIL reset_exit[%0d] Run got %b want %b", i, bus.Run, s[i].run); end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_ldi;
    step_t s[$];
    apply_reset(instr(1));
    s.push_back(sn(20'd0, 1'b0));
    s.push_back(sn(C_T0, 1'b1));
    s.push_back(sn(C_T1, 1'b1));
    s.push_back(sn(C_T2, 1'b1));
    s.push_back(sn(GRB | BAOUT | YIN, 1'b1));
    s.push_back(sn(COUT | ZIN, 1'b1));
    s.push_back(sn(C_WB, 1'b1));
    s.push_back(sn(C_T0, 1'b1));
    foreach (s[i]) begin
      Clear = s[i].clr; bus.MemReady = s[i].mr; bus.Stop = s[i].stop;
      #1;
      checks++; if (bus.Ctl !== s[i].ctl) begin errors++; $display("FAIL ldi[%0d] Ctl got %h want %h", i, bus.Ctl, s[i].ctl); end
      checks++; if (bus.AluOp !== s[i].alu) begin errors++; $display("FAIL ldi[%0d] AluOp got %0d want %0d", i, bus.AluOp, s[i].alu); end
      checks++; if (bus.Run !== s[i].run) begin errors++; $display("FAIL ldi[%0d] Run got %b want %b", i, bus.Run, s[i].run); end
      checks++; if (bus.IllegalOp !== s[i].ill) begin errors++; $display("FAIL ldi[%0d] IllegalOp got %b want %b", i, bus.IllegalOp, s[i].ill); end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_ld_wait;
    step_t s[$];
    apply_reset(instr(0));
    s.push_back(sn(20'd0, 1'b0));
    s.push_back(sn(C_T0, 1'b1));
    s.push_back(sn(C_T1, 1'b1));
    s.push_back(sn(C_T2, 1'b1));
    s.push_back(sn(GRB | BAOUT | YIN, 1'b1));
    s.push_back(sn(COUT | ZIN, 1'b1));
    s.push_back(sn(ZLOW | MARIN, 1'b1));
    for (int k = 0; k < 3; k++) s.push_back(st(1'b1, 1'b0, 1'b0, READ | MDRIN, 4'd0, 1'b1, 1'b0));
    s.push_back(sn(READ | MDRIN, 1'b1));
    s.push_back(sn(MDROUT | GRA | RIN, 1'b1));
    s.push_back(sn(C_T0, 1'b1));  // 11 cycles after the first T0
    foreach (s[i]) begin
      Clear = s[i].clr; bus.MemReady = s[i].mr; bus.Stop = s[i].stop;
      #1;
      checks++; if (bus.Ctl !== s[i].ctl) begin errors++; $display("FAIL ld_wait[%0d] Ctl got %h want %h", i, bus.Ctl, s[i].ctl); end
      checks++; if (bus.AluOp !== s[i].alu) begin errors++; $display("FAIL ld_wait[%0d] AluOp got %0d want %0d", i, bus.AluOp, s[i].alu); end
      checks++; if (bus.Run !== s[i].run) begin errors++; $display("FAIL ld_wait[%0d] Run got %b want %b", i, bus.Run, s[i].run); end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_st_wait;
    step_t s[$];
    apply_reset(instr(2));
    s.push_back(sn(20'd0, 1'b0));
    s.push_back(sn(C_T0, 1'b1));
    s.push_back(st(1'b1, 1'b0, 1'b0, C_T1W, 4'd0, 1'b1, 1'b0));
    s.push_back(st(1'b1, 1'b0, 1'b0, C_T1W, 4'd0, 1'b1, 1'b0));
    s.push_back(sn(C_T1, 1'b1));
    s.push_back(sn(C_T2, 1'b1));
    s.push_back(sn(GRB | BAOUT | YIN, 1'b1));
    s.push_back(sn(COUT | ZIN, 1'b1));
    s.push_back(sn(ZLOW | MARIN, 1'b1));
    s.push_back(sn(GRA | ROUT | MDRIN, 1'b1));
    s.push_back(st(1'b1, 1'b0, 1'b0, WRITE, 4'd0, 1'b1, 1'b0));
    s.push_back(sn(WRITE, 1'b1));
    s.push_back(sn(C_T0, 1'b1));
    foreach (s[i]) begin
      Clear = s[i].clr; bus.MemReady = s[i].mr; bus.Stop = s[i].stop;
      #1;
      checks++; if (bus.Ctl !== s[i].ctl) begin errors++; $display("FAIL st_wait[%0d] Ctl got %h want %h", i, bus.Ctl, s[i].ctl); end
      checks++; if (bus.Run !== s[i].run) begin errors++; $display("FAIL st_wait[%0d] Run got %b want %b", i, bus.Run, s[i].run); end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_alu_ops;
    int ops [4]  = '{3, 4, 5, 6};
    logic [3:0] codes [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
    for (int k = 0; k < 4; k++) begin
      step_t s[$];
      apply_reset(instr(ops[k]));
      s.push_back(sn(20'd0, 1'b0));
      s.push_back(sn(C_T0, 1'b1));
      s.push_back(sn(C_T1, 1'b1));
      s.push_back(sn(C_T2, 1'b1));
      s.push_back(sn(GRB | ROUT | YIN, 1'b1));
      s.push_back(st(1'b1, 1'b1, 1'b0, GRC | ROUT | ZIN, codes[k], 1'b1, 1'b0));
      s.push_back(sn(C_WB, 1'b1));
      s.push_back(sn(C_T0, 1'b1));
      foreach (s[i]) begin
        Clear = s[i].clr; bus.MemReady = s[i].mr; bus.Stop = s[i].stop;
        #1;
        checks++; if (bus.Ctl !== s[i].ctl) begin errors++; $display("FAIL alu_op%0d[%0d] Ctl got %h want %h", ops[k], i, bus.Ctl, s[i].ctl); end
        checks++; if (bus.AluOp !== s[i].alu) begin errors++; $display("FAIL alu_op%0d[%0d] AluOp got %0d want %0d", ops[k], i, bus.AluOp, s[i].alu); end
        @(posedge Clock); #1;
      end
    end
  endtask

  task automatic test_addi;
    step_t s[$];
    apply_reset(instr(12));
    s.push_back(sn(20'd0, 1'b0));
    s.push_back(sn(C_T0, 1'b1));
    s.push_back(sn(C_T1, 1'b1));
    s.push_back(sn(C_T2, 1'b1));
    s.push_back(sn(GRB | ROUT | YIN, 1'b1));
    s.push_back(sn(COUT | ZIN, 1'b1));
    s.push_back(sn(C_WB, 1'b1));
    s.push_back(sn(C_T0, 1'b1));
    foreach (s[i]) begin
      Clear = s[i].clr; bus.MemReady = s[i].mr; bus.Stop = s[i].stop;
      #1;
      checks++; if (bus.Ctl !== s[i].ctl) begin errors++; $display("FAIL addi[%0d] Ctl got %h want %h", i, bus.Ctl, s[i].ctl); end
      checks++; if (bus.AluOp !== s[i].alu) begin errors++; $display("FAIL addi[%0d] AluOp got %0d want %0d", i, bus.AluOp, s[i].alu); end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_illegal;
    step_t s[$];
    apply_reset(instr(31));
    s.push_back(sn(20'd0, 1'b0));
    s.push_back(sn(C_T0, 1'b1));
    s.push_back(sn(C_T1, 1'b1));
    s.push_back(sn(C_T2, 1'b1));
    s.push_back(st(1'b1, 1'b1, 1'b0, 20'd0, 4'd0, 1'b1, 1'b1));
    s.push_back(sn(C_T0, 1'b1));
    s.push_back(sn(C_T1, 1'b1));
    foreach (s[i]) begin
      Clear = s[i].clr; bus.MemReady = s[i].mr; bus.Stop = s[i].stop;
      #1;
      checks++; if (bus.Ctl !== s[i].ctl) begin errors++; $display("FAIL illegal[%0d] Ctl got %h want %h", i, bus.Ctl, s[i].ctl); end
      checks++; if (bus.IllegalOp !== s[i].ill) begin errors++; $display("FAIL illegal[%0d] IllegalOp got %b want %b", i, bus.IllegalOp, s[i].ill); end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_nop;
    step_t s[$];
    apply_reset(instr(26));
    s.push_back(sn(20'd0, 1'b0));
    s.push_back(sn(C_T0, 1'b1));
    s.push_back(sn(C_T1, 1'b1));
    s.push_back(sn(C_T2, 1'b1));
    s.push_back(sn(C_T0, 1'b1));
    foreach (s[i]) begin
      Clear = s[i].clr; bus.MemReady = s[i].mr; bus.Stop = s[i].stop;
      #1;
      checks++; if (bus.Ctl !== s[i].ctl) begin errors++; $display("FAIL nop[%0d] Ctl got %h want %h", i, bus.Ctl, s[i].ctl); end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_stop;
    step_t s[$];
    apply_reset(instr(3));
    s.push_back(sn(20'd0, 1'b0));
    s.push_back(sn(C_T0, 1'b1));
    // Stop raised mid-instruction must not cut the ADD short.
    s.push_back(st(1'b1, 1'b1, 1'b1, C_T1, 4'd0, 1'b1, 1'b0));
    s.push_back(st(1'b1, 1'b1, 1'b1, C_T2, 4'd0, 1'b1, 1'b0));
    s.push_back(st(1'b1, 1'b1, 1'b1, GRB | ROUT | YIN, 4'd0, 1'b1, 1'b0));
    s.push_back(st(1'b1, 1'b1, 1'b1, GRC | ROUT | ZIN, 4'd0, 1'b1, 1'b0));
    s.push_back(st(1'b1, 1'b1, 1'b1, C_WB, 4'd0, 1'b1, 1'b0));
    s.push_back(st(1'b1, 1'b1, 1'b1, 20'd0, 4'd0, 1'b0, 1'b0));
    s.push_back(st(1'b1, 1'b1, 1'b0, 20'd0, 4'd0, 1'b0, 1'b0));
    s.push_back(sn(C_T0, 1'b1));
    foreach (s[i]) begin
      Clear = s[i].clr; bus.MemReady = s[i].mr; bus.Stop = s[i].stop;
      #1;
      checks++; if (bus.Ctl !== s[i].ctl) begin errors++; $display("FAIL stop[%0d] Ctl got %h want %h", i, bus.Ctl, s[i].ctl); end
      checks++; if (bus.Run !== s[i].run) begin errors++; $display("FAIL stop[%0d] Run got %b want %b", i, bus.Run, s[i].run); end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_halt;
    step_t s[$];
    apply_reset(instr(27));
    s.push_back(sn(20'd0, 1'b0));
    s.push_back(sn(C_T0, 1'b1));
    s.push_back(st(1'b1, 1'b0, 1'b0, C_T1W, 4'd0, 1'b1, 1'b0));
    s.push_back(st(1'b0, 1'b0, 1'b0, C_T1W, 4'd0, 1'b1, 1'b0));  // Clear mid-wait
    s.push_back(sn(20'd0, 1'b0));
    s.push_back(sn(C_T0, 1'b1));
    s.push_back(sn(C_T1, 1'b1));
    s.push_back(sn(C_T2, 1'b1));
    for (int k = 0; k < 4; k++) s.push_back(sn(20'd0, 1'b0));   // HALT, Stop=0
    s.push_back(st(1'b0, 1'b1, 1'b0, 20'd0, 4'd0, 1'b0, 1'b0));
    s.push_back(sn(20'd0, 1'b0));
    s.push_back(sn(C_T0, 1'b1));
    foreach (s[i]) begin
      Clear = s[i].clr; bus.MemReady = s[i].mr; bus.Stop = s[i].stop;
      #1;
      checks++; if (bus.Ctl !== s[i].ctl) begin errors++; $display("FAIL halt[%0d] Ctl got %h want %h", i, bus.Ctl, s[i].ctl); end
      checks++; if (bus.Run !== s[i].run) begin errors++; $display("FAIL halt[%0d] Run got %b want %b", i, bus.Run, s[i].run); end
      @(posedge Clock); #1;
    end
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    Clear        = 1'b0;
    bus.IR       = '0;
    bus.Stop     = 1'b0;
    bus.MemReady = 1'b1;
    test_reset();
    test_ldi();
    test_ld_wait();
    test_st_wait();
    test_alu_ops();
    test_addi();
    test_illegal();
    test_nop();
    test_stop();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
